// File: rtl/kronos_mem_arbiter.sv
// Two-requester memory arbiter: shares one req/gnt port between fetch (read-only) and LSU data.
// Data has priority; a starvation counter forces fetch to win after STARVE_MAX data grants.
module kronos_mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rstz,

    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output logic [31:0] instr_data,
    output logic        instr_gnt,

    input  logic [31:0] data_addr,
    input  logic [31:0] data_wr_data,
    input  logic [3:0]  data_wr_mask,
    input  logic        data_rd_req,
    input  logic        data_wr_req,
    output logic [31:0] data_rd_data,
    output logic        data_gnt,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_wr_mask,
    output logic        mem_rd_req,
    output logic        mem_wr_req,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_gnt,

    output logic [1:0]  arb_owner
);

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StInstr = 2'd1,
        StData  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       data_req;

    assign data_req = data_rd_req | data_wr_req;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q      <= StIdle;
            starve_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (instr_req && (!data_req || starve_cnt_q == StarveMax)) begin
                    state_d      = StInstr;
                    starve_cnt_d = 4'd0;
                end else if (data_req) begin
                    state_d = StData;
                    if (instr_req && starve_cnt_q != StarveMax) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end
            end
            // A dropped request (abort) also returns to idle without a grant.
            StInstr: if (mem_gnt || !instr_req) state_d = StIdle;
            StData:  if (mem_gnt || !data_req) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_addr     = 32'd0;
        mem_wr_data  = 32'd0;
        mem_wr_mask  = 4'd0;
        mem_rd_req   = 1'b0;
        mem_wr_req   = 1'b0;
        instr_gnt    = 1'b0;
        instr_data   = 32'd0;
        data_gnt     = 1'b0;
        data_rd_data = 32'd0;
        arb_owner    = state_q;
        unique case (state_q)
            StInstr: begin
                mem_addr   = instr_addr;
                mem_rd_req = instr_req;
                instr_gnt  = mem_gnt & instr_req;
                instr_data = mem_rd_data;
            end
            StData: begin
                mem_addr     = data_addr;
                mem_wr_data  = data_wr_data;
                mem_wr_mask  = data_wr_mask;
                mem_rd_req   = data_rd_req;
                mem_wr_req   = data_wr_req;
                data_gnt     = mem_gnt & data_req;
                data_rd_data = mem_rd_data;
            end
            default: ;
        endcase
    end

endmodule
